multiword_add_seq: RTL and testbench

//  Sequential multi-word adder wrapped around one CHUNK-bit ripple adder stage.
//  - Accepts a WIDTH-bit operand pair over a valid/ready handshake.
//  - Feeds the pair to the chunk adder one chunk per clock, LSB first.
//  - Carries between chunks through a register.
//  - Presents the WIDTH-bit sum and carry-out over a valid/ready handshake.

---
 rtl/adder_pkg.sv | 13 +
 rtl/multiword_add_seq_chunk_adder.sv | 25 ++
 rtl/multiword_add_seq.sv | 149 ++++++++++++++
 tb/tb_multiword_add_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and default sizing for the sequential multi-word adder.
package adder_pkg;

  localparam int ADD_WIDTH = 16;
  localparam int ADD_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } addseq_state_t;

endpackage

// File: rtl/multiword_add_seq_chunk_adder.sv
// CHUNK-bit combinational ripple adder built from full-adder cells.
module chunk_adder
  import adder_pkg::*;
#(
  parameter int CHUNK = ADD_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential WIDTH-bit adder: one CHUNK-bit slice per clock, LSB first.
// Optional MULTIWORD_ADD_SUB_EN adds a subtract request (sub) and signed overflow flag (ovf).
module multiword_add_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int CHUNK = ADD_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef MULTIWORD_ADD_SUB_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("multiword_add_seq: WIDTH must be a nonzero multiple of CHUNK");
  end

  addseq_state_t    state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout;
  logic [WIDTH-1:0] ch_ext;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef MULTIWORD_ADD_SUB_EN
  logic ovf_q, ovf_d;

  // Subtraction is a + ~b + 1; cin has no meaning in that mode.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub | cin;
  assign ovf        = ovf_q;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  always_comb begin
    ch_ext              = '0;
    ch_ext[CHUNK-1:0]   = ch_sum;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef MULTIWORD_ADD_SUB_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = (sum_q >> CHUNK) | (ch_ext << (WIDTH - CHUNK));
        carry_d = ch_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(N - 1)) begin
          cout_d  = ch_cout;
          state_d = DONE;
`ifdef MULTIWORD_ADD_SUB_EN
          // Overflow: operand signs agree but the result sign differs.
          ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (ch_sum[CHUNK-1] != a_q[CHUNK-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef MULTIWORD_ADD_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef MULTIWORD_ADD_SUB_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (WIDTH=16, CHUNK=4); covers sub/ovf when MULTIWORD_ADD_SUB_EN is set.
module tb_multiword_add_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef MULTIWORD_ADD_SUB_EN
  logic        sub;
  logic        ovf;
`endif

  int tests = 0;
  int fails = 0;

  multiword_add_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef MULTIWORD_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef MULTIWORD_ADD_SUB_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [15:0] a_v, input logic [15:0] b_v, input logic cin_v,
                         input logic sub_v, output logic [15:0] s, output logic c,
                         output logic o, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    a        = a_v;
    b        = b_v;
    cin      = cin_v;
`ifdef MULTIWORD_ADD_SUB_EN
    sub      = sub_v;
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    s = sum;
    c = cout;
`ifdef MULTIWORD_ADD_SUB_EN
    o = ovf;
`else
    o = sub_v;
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [15:0] r_sum;
  logic        r_cout;
  logic        r_ovf;
  int          r_lat;
  int          seen;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
    sub       = 1'b0;
`endif

    //            a        b        cin   sub   sum      cout  ovf
    vecs.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
    vecs.push_back('{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0});
`ifdef MULTIWORD_ADD_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0});
`endif

    // Reset state after one edge of rst.
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 0);
`ifdef MULTIWORD_ADD_SUB_EN
    chk("rst_ovf", ovf, 0);
`endif
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_job(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, r_sum, r_cout, r_ovf, r_lat);
      chk($sformatf("vec%0d_sum", i), r_sum, vecs[i].exp_sum);
      chk($sformatf("vec%0d_cout", i), r_cout, vecs[i].exp_cout);
      chk($sformatf("vec%0d_latency", i), r_lat, 5);
`ifdef MULTIWORD_ADD_SUB_EN
      chk($sformatf("vec%0d_ovf", i), r_ovf, vecs[i].exp_ovf);
`endif
      chk($sformatf("vec%0d_out_valid_drop", i), out_valid, 0);
    end

    // Backpressure with in_valid held high throughout.
    a        = 16'h1234;
    b        = 16'h4321;
    cin      = 1'b1;
    in_valid = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_run%0d_in_ready", k), in_ready, 0);
      chk($sformatf("bp_run%0d_out_valid", k), out_valid, 0);
      tick();
    end
    chk("bp_out_valid", out_valid, 1);
    chk("bp_sum", sum, 16'h5556);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_hold%0d_out_valid", k), out_valid, 1);
      chk($sformatf("bp_hold%0d_sum", k), sum, 16'h5556);
      chk($sformatf("bp_hold%0d_cout", k), cout, 0);
      chk($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_idle_sum_kept", sum, 16'h5556);
    tick();
    in_valid = 1'b0;
    chk("bp_second_accept", in_ready, 0);
    seen = 0;
    while (!out_valid && seen < 20) begin
      tick();
      seen++;
    end
    chk("bp_second_sum", sum, 16'h5556);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Abort mid-RUN: rst during the second RUN cycle.
    a        = 16'h00FF;
    b        = 16'h0001;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 16'h0000);
    chk("abort_cout", cout, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    run_job(16'h00FF, 16'h0001, 1'b0, 1'b0, r_sum, r_cout, r_ovf, r_lat);
    chk("after_abort_sum", r_sum, 16'h0100);
    chk("after_abort_cout", r_cout, 0);
    chk("after_abort_latency", r_lat, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
